// File: rtl/axis_step_pkg.sv
// Shared definitions for the axis step pacer: FSM state encoding and cfg_data field layout.
package axis_step_pkg;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_WAIT = 2'd1;
    localparam logic [1:0] STATE_FIRE = 2'd2;
    localparam logic [1:0] STATE_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = STATE_IDLE,
        ST_WAIT = STATE_WAIT,
        ST_FIRE = STATE_FIRE,
        ST_DONE = STATE_DONE
    } state_e;

    // cfg_data is a concatenation of CNTR_WIDTH-wide fields; these are field indices.
    localparam int CFG_PERIOD_IDX = 0;
    localparam int CFG_STEPS_IDX  = 1;

endpackage

// File: rtl/axis_step_gap_cntr.sv
// Loadable up-counter with a terminal-value compare; used for gap timing and miss timing.
module axis_step_gap_cntr
    import axis_step_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] term_val,
    output logic             at_term
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;

    // Counter register: load has priority over enable.
    always_ff @(posedge aclk) begin
        if (areset) begin
            count_r <= CNT_ZERO;
        end else if (load) begin
            count_r <= load_val;
        end else if (en) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign at_term = (count_r == term_val);

endmodule

// File: rtl/axis_step_pacer.sv
// Paces an AXI-Stream stepper: grants one step per slot with a programmable gap.
// Define AXIS_STEP_PACER_MISS_EN to count step slots left unused by the stream.
module axis_step_pacer
    import axis_step_pkg::*;
#(
    parameter int CNTR_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [2*CNTR_WIDTH-1:0] cfg_data,
    input  logic                    run,
    input  logic                    step_valid,
    output logic                    trg_flag,
    output logic [CNTR_WIDTH-1:0]   sts_data,
    output logic [CNTR_WIDTH-1:0]   sts_miss,
    output logic                    busy,
    output logic                    done
);

    localparam int PERIOD_LSB = CFG_PERIOD_IDX * CNTR_WIDTH;
    localparam int STEPS_LSB  = CFG_STEPS_IDX * CNTR_WIDTH;
    localparam logic [CNTR_WIDTH-1:0] CNT_ZERO = {CNTR_WIDTH{1'b0}};
    localparam logic [CNTR_WIDTH-1:0] CNT_ONE  = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

    state_e                  state_r;
    logic                    trg_flag_r;
    logic [CNTR_WIDTH-1:0]   period_r;
    logic [CNTR_WIDTH-1:0]   steps_r;
    logic [CNTR_WIDTH-1:0]   sts_data_r;
    logic [CNTR_WIDTH-1:0]   sts_inc_s;
    logic [CNTR_WIDTH-1:0]   cfg_period_s;
    logic [CNTR_WIDTH-1:0]   cfg_steps_s;
    logic                    start_s;
    logic                    hs_s;
    logic                    last_step_s;
    logic                    gap_term_s;

    // Decode of config fields, start/handshake qualifiers and the next step count.
    always_comb begin
        cfg_period_s = cfg_data[PERIOD_LSB +: CNTR_WIDTH];
        cfg_steps_s  = cfg_data[STEPS_LSB +: CNTR_WIDTH];
        start_s      = (state_r == ST_IDLE) && run;
        hs_s         = trg_flag_r && step_valid;
        sts_inc_s    = sts_data_r + CNT_ONE;
        last_step_s  = (steps_r != CNT_ZERO) && (sts_inc_s == steps_r);
    end

    // Gap counter restarts at 1 whenever a WAIT phase is about to begin.
    axis_step_gap_cntr #(
        .WIDTH (CNTR_WIDTH)
    ) u_gap_cntr (
        .aclk     (aclk),
        .areset   (areset),
        .load     (start_s || hs_s),
        .load_val (CNT_ONE),
        .en       (state_r == ST_WAIT),
        .term_val (period_r),
        .at_term  (gap_term_s)
    );

    // Sequencer FSM with latched config, step count and registered trg_flag.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r    <= ST_IDLE;
            trg_flag_r <= 1'b0;
            period_r   <= CNT_ZERO;
            steps_r    <= CNT_ZERO;
            sts_data_r <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (run) begin
                        period_r   <= cfg_period_s;
                        steps_r    <= cfg_steps_s;
                        sts_data_r <= CNT_ZERO;
                        if (cfg_period_s == CNT_ZERO) begin
                            state_r    <= ST_FIRE;
                            trg_flag_r <= 1'b1;
                        end else begin
                            state_r    <= ST_WAIT;
                            trg_flag_r <= 1'b0;
                        end
                    end else begin
                        trg_flag_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (!run) begin
                        state_r    <= ST_IDLE;
                        trg_flag_r <= 1'b0;
                    end else if (gap_term_s) begin
                        state_r    <= ST_FIRE;
                        trg_flag_r <= 1'b1;
                    end else begin
                        trg_flag_r <= 1'b0;
                    end
                end
                ST_FIRE: begin
                    // A handshake in the abort cycle is still counted.
                    if (hs_s) begin
                        sts_data_r <= sts_inc_s;
                    end else begin
                        sts_data_r <= sts_data_r;
                    end
                    if (!run) begin
                        state_r    <= ST_IDLE;
                        trg_flag_r <= 1'b0;
                    end else if (hs_s && last_step_s) begin
                        state_r    <= ST_DONE;
                        trg_flag_r <= 1'b0;
                    end else if (hs_s && (period_r != CNT_ZERO)) begin
                        state_r    <= ST_WAIT;
                        trg_flag_r <= 1'b0;
                    end else begin
                        trg_flag_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    trg_flag_r <= 1'b0;
                    if (!run) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    trg_flag_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef AXIS_STEP_PACER_MISS_EN
    logic                  miss_en_s;
    logic                  miss_term_s;
    logic [CNTR_WIDTH-1:0] sts_miss_r;

    // A missed slot is period+1 consecutive FIRE cycles without a handshake.
    always_comb begin
        miss_en_s = trg_flag_r && !step_valid && (period_r != CNT_ZERO);
    end

    axis_step_gap_cntr #(
        .WIDTH (CNTR_WIDTH)
    ) u_miss_cntr (
        .aclk     (aclk),
        .areset   (areset),
        .load     (start_s || hs_s || (miss_en_s && miss_term_s)),
        .load_val (CNT_ZERO),
        .en       (miss_en_s),
        .term_val (period_r),
        .at_term  (miss_term_s)
    );

    // Missed-slot status counter, cleared at sequence start.
    always_ff @(posedge aclk) begin
        if (areset) begin
            sts_miss_r <= CNT_ZERO;
        end else if (start_s) begin
            sts_miss_r <= CNT_ZERO;
        end else if (miss_en_s && miss_term_s) begin
            sts_miss_r <= sts_miss_r + CNT_ONE;
        end else begin
            sts_miss_r <= sts_miss_r;
        end
    end

    assign sts_miss = sts_miss_r;
`else
    assign sts_miss = CNT_ZERO;
`endif

    assign trg_flag = trg_flag_r;
    assign sts_data = sts_data_r;
    assign busy     = (state_r == ST_WAIT) || (state_r == ST_FIRE);
    assign done     = (state_r == ST_DONE);

endmodule

// File: doc/axis_step_pacer.md
AXIS_STEP_PACER -- requirements
Module: axis_step_pacer

Interface
REQ-001 SHALL have parameter CNTR_WIDTH, default 32: width of the period, step-count and status counters.
REQ-002 SHALL have port aclk, input, 1: single clock; all logic on its rising edge.
REQ-003 SHALL have port areset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port cfg_data, input, 2*CNTR_WIDTH: [CNTR_WIDTH-1:0] is period (gap cycles between steps); [2*CNTR_WIDTH-1:CNTR_WIDTH] is steps (0 means continuous).
REQ-005 SHALL have port run, input, 1: level enable; rising level starts a sequence, low aborts or re-arms.
REQ-006 SHALL have port step_valid, input, 1: tvalid of the paced stream; a step transfers when trg_flag && step_valid.
REQ-007 SHALL have port trg_flag, output, 1: registered step permission, drives the stepper tready gate.
REQ-008 SHALL have port sts_data, output, CNTR_WIDTH: steps transferred in the current or last sequence.
REQ-009 SHALL have port sts_miss, output, CNTR_WIDTH: missed step slots.
REQ-010 SHALL have port busy, output, 1: high in WAIT or FIRE.
REQ-011 SHALL have port done, output, 1: high in DONE.

Function
REQ-012 SHALL implement states IDLE, WAIT, FIRE, DONE; trg_flag=1 only in FIRE; busy and done decoded from the state register.
REQ-013 IDLE with run=1 SHALL latch cfg_data, clear sts_data and sts_miss, and go to FIRE if period==0, else to WAIT with gap counter=1.
REQ-014 WAIT SHALL increment the gap counter each cycle and go to FIRE in the cycle after the counter equals period, giving exactly period trg_flag-low cycles.
REQ-015 In FIRE, a handshake SHALL increment sts_data; if steps!=0 and the new count equals steps, go to DONE; else stay in FIRE if period==0, else go to WAIT with gap counter=1.
REQ-016 FIRE without a handshake SHALL hold trg_flag high indefinitely; no handshake SHALL be counted outside FIRE.
REQ-017 With steps==0, sts_data SHALL count continuously and wrap modulo 2^CNTR_WIDTH; DONE is never entered.
REQ-018 DONE SHALL hold sts_data and go to IDLE when run==0.
REQ-019 run==0 in WAIT or FIRE SHALL abort to IDLE: trg_flag low from the next cycle, sts_data and sts_miss held; a handshake in the abort cycle still counts.
REQ-020 cfg_data changes SHALL have no effect until the next IDLE->start.
REQ-021 Latency: run sampled high at cycle 0 gives first trg_flag at cycle period+1; handshake at cycle t gives next trg_flag at cycle t+period+1.

Reset
REQ-022 areset SHALL force IDLE, trg_flag=0, busy=0, done=0, sts_data=0, sts_miss=0, gap and miss counters=0, and the latched config=0, overriding all other inputs in that cycle.
REQ-023 areset mid-sequence SHALL discard the sequence; a new sequence needs run sampled high after reset release.

Configuration
REQ-024 Macro AXIS_STEP_PACER_MISS_EN defined: while in FIRE without a handshake and period!=0, a miss counter SHALL count cycles; each time it reaches period+1, sts_miss increments (wrapping) and the miss counter restarts; any handshake clears the miss counter.
REQ-025 Macro undefined: no miss logic SHALL be generated and sts_miss is constant 0; all other behaviour is identical.

Structure
REQ-026 State encoding localparams (IDLE, WAIT, FIRE, DONE) and the cfg_data field offsets SHALL live in shared package axis_step_pkg.
REQ-027 The gap/miss counting SHALL be one sub-module, axis_step_gap_cntr (load, enable, terminal-compare output); the FSM and status registers stay in axis_step_pacer.

Verification
REQ-028 period=3, steps=4, step_valid=1, run high at cycle 0: trg_flag high at cycles 4, 8, 12, 16; done at 17; sts_data=4.
REQ-029 period=0, steps=0, step_valid=1 for 10 cycles: trg_flag continuously high from cycle 1; sts_data=10; done stays 0.
REQ-030 period=2, steps=2, step_valid low for 7 FIRE cycles then high (MISS_EN): sts_miss=2; trg_flag holds high; sts_data increments on the handshake.
REQ-031 period=5, steps=10, run dropped after 3 steps: IDLE next cycle, trg_flag=0, sts_data=3; re-raising run restarts with sts_data=0.
REQ-032 areset asserted in FIRE with step_valid=1: next cycle all outputs 0; no step counted.
REQ-033 steps=0, CNTR_WIDTH=4, period=0, 17 handshakes: sts_data wraps to 1.
